// File: rtl/axi_allocator_pkg.sv
// Shared types and the round-robin pick helper for the AW allocator.
package axi_allocator_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } aw_state_e;

  // rr_pick works on a fixed-size request vector; callers zero-extend.
  localparam int unsigned RR_MAX_REQ = 64;
  localparam int unsigned RR_IDX_W   = 6;

  // First asserted request scanning ptr, ptr+1, ... wrapping modulo n.
  function automatic logic [RR_IDX_W-1:0] rr_pick(
    input logic [RR_MAX_REQ-1:0] req,
    input logic [RR_IDX_W-1:0]   ptr,
    input int unsigned           n
  );
    logic [RR_IDX_W-1:0] pick;
    logic                found;
    logic [RR_IDX_W:0]   idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < RR_MAX_REQ; i++) begin
      idx = {1'b0, ptr} + (RR_IDX_W+1)'(i);
      if (idx >= (RR_IDX_W+1)'(n)) idx = idx - (RR_IDX_W+1)'(n);
      if (!found && (i < n) && req[idx[RR_IDX_W-1:0]]) begin
        pick  = idx[RR_IDX_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/axi_aw_allocator_if.sv
// AW arbitration and W-steering signals between requesters, slave port and allocator.
interface axi_aw_allocator_if #(
  parameter int unsigned N_TARG_PORT = 8
);
  localparam int unsigned LOG_N_TARG = $clog2(N_TARG_PORT);

  logic [N_TARG_PORT-1:0] awvalid_i;
  logic [N_TARG_PORT-1:0] awready_o;
  logic                   awvalid_o;
  logic                   awready_i;
  logic [LOG_N_TARG-1:0]  aw_sel_o;
  logic [LOG_N_TARG-1:0]  wsel_o;
  logic                   wsel_valid_o;
  logic                   wsel_pop_i;
  logic                   fifo_full_o;

  modport slave (
    input  awvalid_i, awready_i, wsel_pop_i,
    output awready_o, awvalid_o, aw_sel_o, wsel_o, wsel_valid_o, fifo_full_o
  );

  modport master (
    output awvalid_i, awready_i, wsel_pop_i,
    input  awready_o, awvalid_o, aw_sel_o, wsel_o, wsel_valid_o, fifo_full_o
  );

endinterface

// File: rtl/axi_index_fifo.sv
// Small index FIFO with combinational head read; pushes when full and pops when empty are dropped.
module axi_index_fifo
  import axi_allocator_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 3,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic                  push_ok;
  logic                  pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr_q] <= din;
        wr_ptr_q      <= wr_ptr_q + AW'(1);
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  a_no_empty_pop: assert property (@(posedge clk) disable iff (!rst_n) pop |-> !empty)
    else $warning("pop on empty W-index FIFO ignored");

endmodule

// File: rtl/axi_aw_allocator.sv
// Round-robin AW allocator: one slave-side AW channel shared by N requesters, W order kept in a FIFO.
module axi_aw_allocator
  import axi_allocator_pkg::*;
#(
  parameter int unsigned N_TARG_PORT = 8,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input logic                clk,
  input logic                rst_n,
  axi_aw_allocator_if.slave  bus
);

  localparam int unsigned LOG_N_TARG = $clog2(N_TARG_PORT);

  if (N_TARG_PORT > RR_MAX_REQ) begin : g_size_check
    $error("N_TARG_PORT exceeds rr_pick capacity");
  end

  aw_state_e             state_q;
  aw_state_e             state_d;
  logic [LOG_N_TARG-1:0] rr_ptr_q;
  logic [LOG_N_TARG-1:0] gnt_q;
  logic [LOG_N_TARG-1:0] winner;
  logic [LOG_N_TARG-1:0] push_idx;
  logic                  push;
  logic                  any_req;
  logic                  grant_ok;
  logic                  full;
  logic                  empty;

  assign any_req  = |bus.awvalid_i;
  // Full check uses registered count, so a same-cycle pop cannot free a slot for this grant.
  assign grant_ok = any_req && !full;
  assign winner   = LOG_N_TARG'(rr_pick(RR_MAX_REQ'(bus.awvalid_i), RR_IDX_W'(rr_ptr_q), N_TARG_PORT));

  assign bus.fifo_full_o  = full;
  assign bus.wsel_valid_o = !empty;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_ok && !bus.awready_i) state_d = LOCKED;
      LOCKED:  if (bus.awready_i)              state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: zero-latency grant in IDLE, held grant in LOCKED.
  always_comb begin
    bus.awvalid_o = 1'b0;
    bus.aw_sel_o  = '0;
    bus.awready_o = '0;
    push          = 1'b0;
    push_idx      = '0;
    case (state_q)
      IDLE: begin
        if (grant_ok) begin
          bus.awvalid_o = 1'b1;
          bus.aw_sel_o  = winner;
          if (bus.awready_i) begin
            bus.awready_o[winner] = 1'b1;
            push                  = 1'b1;
            push_idx              = winner;
          end
        end
      end
      LOCKED: begin
        bus.awvalid_o = 1'b1;
        bus.aw_sel_o  = gnt_q;
        if (bus.awready_i) begin
          bus.awready_o[gnt_q] = 1'b1;
          push                 = 1'b1;
          push_idx             = gnt_q;
        end
      end
      default: ;
    endcase
  end

  // Round-robin pointer and locked grant index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      gnt_q    <= '0;
    end else begin
      if (push) begin
        rr_ptr_q <= (push_idx == LOG_N_TARG'(N_TARG_PORT - 1)) ? '0 : push_idx + LOG_N_TARG'(1);
      end
      if (state_q == IDLE && state_d == LOCKED) gnt_q <= winner;
    end
  end

  axi_index_fifo #(
    .DATA_WIDTH (LOG_N_TARG),
    .DEPTH      (FIFO_DEPTH)
  ) u_wsel_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (bus.wsel_pop_i),
    .din   (push_idx),
    .dout  (bus.wsel_o),
    .full  (full),
    .empty (empty)
  );

  a_lock_held: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == LOCKED) |-> bus.awvalid_i[gnt_q])
    else $error("requester dropped awvalid while its grant was locked");

  a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.awready_o))
    else $error("more than one awready_o bit asserted");

  a_ready_qualified: assert property (@(posedge clk) disable iff (!rst_n)
    (|bus.awready_o) |-> (bus.awvalid_o && bus.awready_i))
    else $error("awready_o without slave handshake");

endmodule
